// File: rtl/waypoint_pkg.sv
// Shared types and defaults for the waypoint collector.
// Holds the collector state enum, the packed coordinate struct and default grid bounds.
package waypoint_pkg;

  localparam int PKG_COORD_W    = 8;
  localparam int DEFAULT_GRID_W = 160;
  localparam int DEFAULT_GRID_H = 120;

  typedef enum logic {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } state_t;

  typedef struct packed {
    logic [PKG_COORD_W-1:0] y;
    logic [PKG_COORD_W-1:0] x;
  } coord_t;

endpackage

// File: rtl/rise_detect.sv
// One-bit rising-edge detector: rise is high while d=1 and the registered previous value is 0.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev <= 1'b0;
    end else begin
      prev <= d;
    end
  end

  assign rise = d & ~prev;

endmodule

// File: rtl/waypoint_collector.sv
// Collects button-entered grid coordinates, validates them, and writes accepted
// points as packed {y, x} words to consecutive waypoint RAM addresses.
module waypoint_collector
  import waypoint_pkg::*;
#(
  parameter int COORD_W = 8,
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int GRID_W  = DEFAULT_GRID_W,
  parameter int GRID_H  = DEFAULT_GRID_H,
  parameter int DEDUP   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [COORD_W-1:0]   x_in,
  input  logic [COORD_W-1:0]   y_in,
  input  logic                 write_en,
  input  logic                 enter_coord,
  input  logic                 finish_init,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [2*COORD_W-1:0] mem_data,
  output logic                 mem_wren,
  output logic [ADDR_W:0]      count,
  output logic                 full,
  output logic                 reject,
  output logic                 done,
  output logic [3:0]           hex0,
  output logic [3:0]           hex1,
  output logic [3:0]           hex2,
  output logic [3:0]           hex3,
  output logic [3:0]           hex4,
  output logic [3:0]           hex5
);

  // One extra bit on the bound constants so a full-range grid still compares correctly
  localparam logic [COORD_W:0] GRID_W_C = (COORD_W+1)'(GRID_W);
  localparam logic [COORD_W:0] GRID_H_C = (COORD_W+1)'(GRID_H);
  localparam logic [ADDR_W:0]  DEPTH_C  = (ADDR_W+1)'(DEPTH);

  state_t               state;
  state_t               next_state;
  logic                 btn_rise;
  logic                 press;
  logic                 in_bounds;
  logic                 dup;
  logic                 accept;
  logic                 refuse_press;
  logic                 refuse_finish;
  logic [ADDR_W:0]      count_inc;
  logic [2*COORD_W-1:0] last_pt;
  logic [7:0]           hex_x;
  logic [7:0]           hex_y;
  logic [7:0]           hex_cnt;

  rise_detect u_enter_rise (
    .clk   (clk),
    .reset (reset),
    .d     (enter_coord),
    .rise  (btn_rise)
  );

  assign press     = btn_rise & write_en;
  assign count_inc = count + (ADDR_W+1)'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= COLLECT;
    end else begin
      state <= next_state;
    end
  end

  // A press accepted in the same cycle as finish still counts toward leaving COLLECT
  always_comb begin
    next_state    = state;
    accept        = 1'b0;
    refuse_press  = 1'b0;
    refuse_finish = 1'b0;
    in_bounds     = ({1'b0, x_in} < GRID_W_C) && ({1'b0, y_in} < GRID_H_C);
    dup           = (DEDUP != 0) && (count != '0) && ({y_in, x_in} == last_pt);
    if (state == COLLECT) begin
      if (press) begin
        if (in_bounds && !full && !dup) begin
          accept = 1'b1;
        end else begin
          refuse_press = 1'b1;
        end
      end
      if (finish_init) begin
        if ((count != '0) || accept) begin
          next_state = DONE;
        end else begin
          refuse_finish = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_wren <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      count    <= '0;
      full     <= 1'b0;
      reject   <= 1'b0;
      done     <= 1'b0;
      last_pt  <= '0;
    end else begin
      mem_wren <= accept;
      reject   <= refuse_press | refuse_finish;
      if (accept) begin
        mem_addr <= count[ADDR_W-1:0];
        mem_data <= {y_in, x_in};
        last_pt  <= {y_in, x_in};
        count    <= count_inc;
        full     <= (count_inc == DEPTH_C);
      end
      if (next_state == DONE) begin
        done <= 1'b1;
      end
    end
  end

  // Only the low byte of each value fits on a pair of digits
  assign hex_x   = 8'(last_pt[COORD_W-1:0]);
  assign hex_y   = 8'(last_pt[2*COORD_W-1:COORD_W]);
  assign hex_cnt = 8'(count);

  assign hex0 = hex_x[3:0];
  assign hex1 = hex_x[7:4];
  assign hex2 = hex_y[3:0];
  assign hex3 = hex_y[7:4];
  assign hex4 = hex_cnt[3:0];
  assign hex5 = hex_cnt[7:4];

endmodule

// File: doc/waypoint_collector.md
# waypoint_collector

Parametrised successor to the coordinate collector: accepts user-entered (x, y) grid coordinates one button press at a time, validates them against the grid bounds, optionally drops consecutive duplicates, and writes accepted points into the waypoint RAM as packed {y, x} words at consecutive addresses. It sits between the board switches/buttons and the waypoint memory read by the pathfinding core. It reports the count, full and done status to that core, and drives the six 7-segment digits.

## Interface
Parameters:
- COORD_W, 8: width of each of x and y.
- DEPTH, 256: maximum number of stored waypoints.
- ADDR_W, $clog2(DEPTH): memory address width.
- GRID_W, 160: valid x range is 0..GRID_W-1.
- GRID_H, 120: valid y range is 0..GRID_H-1.
- DEDUP, 1: when 1, reject a point identical to the last accepted point.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-low reset.
- x_in  in  COORD_W  switch x value.
- y_in  in  COORD_W  switch y value.
- write_en  in  1  collection enable; presses are ignored while low.
- enter_coord  in  1  level from the push button; edge-detected internally.
- finish_init  in  1  level; request to end collection.
- mem_addr  out  ADDR_W  write address.
- mem_data  out  2*COORD_W  {y, x}.
- mem_wren  out  1  one-cycle write strobe.
- count  out  ADDR_W+1  number of accepted points.
- full  out  1  count == DEPTH.
- reject  out  1  one-cycle pulse for a refused press or finish.
- done  out  1  collection finished; held high.
- hex0..hex5  out  4 each  nibbles for the 7-segment digits.

## Operation
- States are COLLECT and DONE. Reset enters COLLECT.
- Press event:
  - An internal register holds the previous enter_coord value.
  - A press is a cycle with enter_coord=1, previous=0 and write_en=1.
  - A held button produces exactly one event.
- A press in COLLECT is refused when any of the following holds:
  - x_in >= GRID_W or y_in >= GRID_H.
  - full is high.
  - DEDUP=1, count>0 and {y_in, x_in} equals the last accepted point.
- A refused press pulses reject for one cycle. No write occurs and count is unchanged.
- An accepted press registers, on the same edge:
  - mem_wren<=1, mem_addr<=count[ADDR_W-1:0], mem_data<={y_in, x_in}.
  - count<=count+1.
  - The last-accepted register is updated.
- mem_wren is high for exactly one cycle per accepted press.
- finish_init=1 in COLLECT:
  - If count>0, or a press is accepted in the same cycle: go to DONE and set done=1.
  - Otherwise pulse reject and stay in COLLECT.
- A press and finish_init in the same cycle: the point is written and counted first, then the block enters DONE.
- DONE: all inputs except reset are ignored. mem_wren=0, done=1. The block stays here until reset.
- count saturates at DEPTH and never wraps. No address past DEPTH-1 is ever written.
- Hex digits:
  - hex1:hex0 = last accepted x[7:0].
  - hex3:hex2 = last accepted y[7:0].
  - hex5:hex4 = count[7:0].
  - Bits above 8 are not displayed.

## Timing
- Reset (reset=0 at a clk edge) gives the following values on the next cycle:
  - state=COLLECT.
  - mem_wren=0, mem_addr=0, mem_data=0.
  - count=0, full=0, reject=0, done=0.
  - All hex digits 0; last-accepted point 0; previous-button register 0.
- Reset in the middle of operation takes priority over any press or finish in the same cycle.
- Latency: a press sampled at edge N drives mem_wren/mem_addr/mem_data and the updated count during cycle N+1. reject follows the same one-cycle latency.
- full and the hex digits are registered and update with count.
- No handshake exists with the RAM: it must accept a write every cycle.

## Structure
- Package waypoint_pkg holds:
  - The state enum (COLLECT, DONE).
  - A packed struct coord_t {y, x}, parametrised through COORD_W localparams.
  - Default constants for GRID_W and GRID_H.
- Sub-module rise_detect: a one-bit registered rising-edge detector with synchronous active-low reset, instantiated once for enter_coord.

## Test plan
- Reset, then 3 presses at (5,7), (10,20), (159,119) -> mem_wren pulses at addresses 0, 1, 2 with data 0x0705, 0x140A, 0x779F; count=3.
- Press (160,0), then (0,120) -> reject pulses twice, no mem_wren, count unchanged.
- DEDUP=1: press (3,3) twice, then hold enter_coord high for 10 cycles -> one write, one reject, count=1.
- DEPTH=4: six valid distinct presses -> 4 writes at addresses 0..3, full=1, two rejects, count=4.
- finish_init with count=0 -> reject, done=0. Then press (1,2) together with finish_init -> write at addr 0, count=1, done=1. A later press -> no write.
- Reset asserted mid-sequence after 2 writes -> count=0, done=0, hex=0. The next press writes address 0.
